dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the byte-addressed, big-endian data memory.
//  Requester 0 is the core load/store unit; requester 1 is the DMA/debug port.
//  Each request is granted round-robin, bounds- and length-checked, and driven onto the memory for exactly one cycle.
//  The result (read data or write acknowledge, plus error flag) is returned through a valid/ready response.
// PARAMETERS
//  MEM_DEPTH  100  number of bytes in the data memory; valid byte addresses are 0..MEM_DEPTH-1
// PORTS
//  SYS_clk            in   1   system clock; all state updates on the rising edge
//  SYS_reset          in   1   asynchronous, active-low reset
//  REQ_valid          in   2   per-requester request valid; bit g belongs to requester g
//  REQ_ready          out  2   per-requester request accept; a handshake occurs when valid and ready are both 1
//  REQ_write          in   2   per-requester 1 = store, 0 = load
//  REQ_length         in   4   [2g+1:2g] 01 = byte, 10 = half-word, 11 = word, 00 = illegal
//  REQ_signed         in   2   per-requester load sign-extension enable
//  REQ_addr           in   64  [32g+31:32g] byte address
//  REQ_wdata          in   64  [32g+31:32g] store data; the used bytes are right-aligned
//  RSP_valid          out  2   per-requester response valid; at most one bit is set at a time
//  RSP_ready          in   2   per-requester response accept
//  RSP_rdata          out  32  load result, qualified by RSP_valid; 0 for stores and for errors
//  RSP_err            out  1   response error flag, qualified by RSP_valid
//  MEM_read_address   out  32  memory read address
//  MEM_read_length    out  2   memory read length
//  MEM_read_signed    out  1   memory read sign-extension enable
//  MEM_write_address  out  32  memory write address
//  MEM_write_length   out  2   memory write length; 00 = no write
//  MEM_write_data     out  32  memory write data
//  MEM_read_data      in   32  memory read data; combinational from the MEM_read_* inputs
// BEHAVIOUR
//  FSM states: IDLE -> ACCESS -> RESP -> IDLE.
//  - Minimum transaction time is 3 cycles.
//  - Only one transaction is in flight at a time.
//  IDLE
//  - REQ_ready[g] = REQ_valid[g] & grant[g], decided combinationally.
//  - If only one bit of REQ_valid is set, that requester is granted.
//  - If both bits are set, the requester other than last_grant is granted.
//  - On the handshake edge, latch g, write, length, signed, addr and wdata, then go to ACCESS.
//  - Requesters must hold request fields stable while valid and not ready.
//  ACCESS (exactly 1 cycle)
//  - ok = (len != 00) && ({1'b0,addr} + nbytes <= MEM_DEPTH), with nbytes = 1/2/4.
//  - The add is 33 bits wide, so addresses near 2^32 do not wrap.
//  - Load with ok:
//    - MEM_read_address = addr, MEM_read_length = len, MEM_read_signed = signed.
//    - Register MEM_read_data into RSP_rdata at the edge; RSP_err <= 0.
//  - Store with ok:
//    - MEM_write_address = addr, MEM_write_length = len, MEM_write_data = wdata.
//    - The write commits at the end of this cycle; RSP_rdata <= 0, RSP_err <= 0.
//  - Not ok: no memory write; RSP_rdata <= 0, RSP_err <= 1.
//  - Misaligned addresses are legal; no alignment check is made.
//  - Next state is RESP.
//  RESP
//  - RSP_valid[g] = 1; RSP_rdata and RSP_err are held stable.
//  - REQ_ready = 00; new requests wait.
//  - On RSP_ready[g]: last_grant <= g, go to IDLE.
//  - RSP_ready of the non-granted requester is ignored.
//  Memory outputs outside ACCESS (and in ACCESS when not ok)
//  - MEM_write_length = 00.
//  - MEM_read_length = 11, MEM_read_signed = 0.
//  - All MEM addresses and MEM_write_data are 0.
//  - MEM_write_length is nonzero only in the ACCESS state, for 1 cycle per handshake.
//  Reset (SYS_reset = 0, asynchronous)
//  - state = IDLE, last_grant = 1 (requester 0 wins the first tie).
//  - RSP_valid = 00, RSP_rdata = 0, RSP_err = 0, REQ_ready forced to 00, all MEM outputs idle.
//  - Reset during ACCESS cancels the pending write; reset during RESP drops the response.
// TESTING
//  1. After reset, write 1 byte to 0x01; store word 0x11223344 @ addr 4 via req0, RSP_ready = 1
//     -> memory bytes 4..7 = 11,22,33,44; RSP_valid[0] 2 cycles after the handshake; RSP_err = 0.
//  2. req1 loads a signed byte @ 4 after mem[4] = 0x80
//     -> RSP_rdata = 0xFFFFFF80; unsigned -> 0x00000080; half-word unsigned @ 4 -> 0x00008022 if mem[5] = 0x22.
//  3. Both REQ_valid held high for 4 transactions -> grant order 0,1,0,1; REQ_ready is never 11.
//  4. Word store @ 97 with MEM_DEPTH = 100 -> RSP_err = 1, MEM_write_length stays 00, memory unchanged.
//     Also: byte @ 99 -> ok; addr 0xFFFFFFFE half-word -> err; length 00 -> err.
//  5. Hold RSP_ready[0] = 0 for 5 cycles -> RSP_valid[0], RSP_rdata and RSP_err stable; req1 REQ_ready stays 0.
//  6. Assert SYS_reset low mid-cycle during ACCESS of a store
//     -> no memory write occurs; RSP_valid = 00; the next request is accepted normally after release.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-requester round-robin arbiter in front of the big-endian data memory.
// Each transaction walks IDLE -> ACCESS -> RESP and drives the memory for exactly one cycle.
module dmem_port_arbiter #(
  parameter int unsigned MEM_DEPTH = 100
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic [1:0]  REQ_valid,
  output logic [1:0]  REQ_ready,
  input  logic [1:0]  REQ_write,
  input  logic [3:0]  REQ_length,
  input  logic [1:0]  REQ_signed,
  input  logic [63:0] REQ_addr,
  input  logic [63:0] REQ_wdata,
  output logic [1:0]  RSP_valid,
  input  logic [1:0]  RSP_ready,
  output logic [31:0] RSP_rdata,
  output logic        RSP_err,
  output logic [31:0] MEM_read_address,
  output logic [1:0]  MEM_read_length,
  output logic        MEM_read_signed,
  output logic [31:0] MEM_write_address,
  output logic [1:0]  MEM_write_length,
  output logic [31:0] MEM_write_data,
  input  logic [31:0] MEM_read_data
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_idx;
  logic [1:0]  gnt_oh;
  logic        hs;

  logic        g_q, write_q, sgn_q;
  logic [1:0]  len_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        ok;

  always_comb begin
    gnt_idx = 1'b0;
    case (REQ_valid)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant_q;
      default: gnt_idx = 1'b0;
    endcase
    gnt_oh = gnt_idx ? 2'b10 : 2'b01;
    // Gate with reset so nothing is accepted while reset is held.
    REQ_ready = (state_q == StIdle && SYS_reset) ? (REQ_valid & gnt_oh) : 2'b00;
    hs = |REQ_ready;
  end

  always_comb begin
    nbytes = 3'd0;
    case (len_q)
      2'b01:   nbytes = 3'd1;
      2'b10:   nbytes = 3'd2;
      2'b11:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap into range.
    end_addr = {1'b0, addr_q} + {30'b0, nbytes};
    ok = (len_q != 2'b00) && (end_addr <= 33'(MEM_DEPTH));
  end

  always_comb begin
    MEM_read_address  = 32'h0;
    MEM_read_length   = 2'b11;
    MEM_read_signed   = 1'b0;
    MEM_write_address = 32'h0;
    MEM_write_length  = 2'b00;
    MEM_write_data    = 32'h0;
    if (state_q == StAccess && ok) begin
      if (write_q) begin
        MEM_write_address = addr_q;
        MEM_write_length  = len_q;
        MEM_write_data    = wdata_q;
      end else begin
        MEM_read_address = addr_q;
        MEM_read_length  = len_q;
        MEM_read_signed  = sgn_q;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      StIdle:   if (hs) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp: begin
        if (RSP_ready[g_q]) begin
          last_grant_d = g_q;
          state_d      = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  assign RSP_valid = (state_q == StResp) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign RSP_rdata = rdata_q;
  assign RSP_err   = err_q;

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      g_q          <= 1'b0;
      write_q      <= 1'b0;
      sgn_q        <= 1'b0;
      len_q        <= 2'b00;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (hs) begin
        g_q     <= gnt_idx;
        write_q <= gnt_idx ? REQ_write[1] : REQ_write[0];
        sgn_q   <= gnt_idx ? REQ_signed[1] : REQ_signed[0];
        len_q   <= gnt_idx ? REQ_length[3:2] : REQ_length[1:0];
        addr_q  <= gnt_idx ? REQ_addr[63:32] : REQ_addr[31:0];
        wdata_q <= gnt_idx ? REQ_wdata[63:32] : REQ_wdata[31:0];
      end
      if (state_q == StAccess) begin
        rdata_q <= (ok && !write_q) ? MEM_read_data : 32'h0;
        err_q   <= !ok;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 100-byte big-endian memory model.
module tb_dmem_port_arbiter;
  localparam int unsigned Depth = 100;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic [1:0]  REQ_valid, REQ_ready, REQ_write, REQ_signed, RSP_valid, RSP_ready;
  logic [3:0]  REQ_length;
  logic [63:0] REQ_addr, REQ_wdata;
  logic [31:0] RSP_rdata, MEM_read_address, MEM_write_address, MEM_write_data, MEM_read_data;
  logic        RSP_err, MEM_read_signed;
  logic [1:0]  MEM_read_length, MEM_write_length;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_writes = 0;
  logic [7:0]  mem [Depth] = '{default: 8'h00};
  int          grant_log [$];
  bit          both_ready_seen = 1'b0;

  dmem_port_arbiter #(.MEM_DEPTH(Depth)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .REQ_valid(REQ_valid), .REQ_ready(REQ_ready), .REQ_write(REQ_write),
    .REQ_length(REQ_length), .REQ_signed(REQ_signed), .REQ_addr(REQ_addr),
    .REQ_wdata(REQ_wdata), .RSP_valid(RSP_valid), .RSP_ready(RSP_ready),
    .RSP_rdata(RSP_rdata), .RSP_err(RSP_err),
    .MEM_read_address(MEM_read_address), .MEM_read_length(MEM_read_length),
    .MEM_read_signed(MEM_read_signed), .MEM_write_address(MEM_write_address),
    .MEM_write_length(MEM_write_length), .MEM_write_data(MEM_write_data),
    .MEM_read_data(MEM_read_data)
  );

  always #5 SYS_clk = ~SYS_clk;

  function automatic logic [7:0] mb(input logic [31:0] a);
    return (a < 32'(Depth)) ? mem[a[6:0]] : 8'h00;
  endfunction

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mb(MEM_read_address);
    b1 = mb(MEM_read_address + 32'd1);
    b2 = mb(MEM_read_address + 32'd2);
    b3 = mb(MEM_read_address + 32'd3);
    case (MEM_read_length)
      2'b01:   MEM_read_data = {{24{MEM_read_signed & b0[7]}}, b0};
      2'b10:   MEM_read_data = {{16{MEM_read_signed & b0[7]}}, b0, b1};
      default: MEM_read_data = {b0, b1, b2, b3};
    endcase
  end

  always @(posedge SYS_clk) begin
    if (REQ_ready == 2'b11) both_ready_seen <= 1'b1;
    if (REQ_ready[0] && REQ_valid[0]) grant_log.push_back(0);
    if (REQ_ready[1] && REQ_valid[1]) grant_log.push_back(1);
    if (MEM_write_length != 2'b00) begin
      n_writes <= n_writes + 1;
      case (MEM_write_length)
        2'b01: mem[MEM_write_address[6:0]] <= MEM_write_data[7:0];
        2'b10: begin
          mem[MEM_write_address[6:0]]         <= MEM_write_data[15:8];
          mem[MEM_write_address[6:0] + 7'd1] <= MEM_write_data[7:0];
        end
        default: begin
          mem[MEM_write_address[6:0]]         <= MEM_write_data[31:24];
          mem[MEM_write_address[6:0] + 7'd1] <= MEM_write_data[23:16];
          mem[MEM_write_address[6:0] + 7'd2] <= MEM_write_data[15:8];
          mem[MEM_write_address[6:0] + 7'd3] <= MEM_write_data[7:0];
        end
      endcase
    end
  end

  // Presents a request at a negedge and returns at the negedge after the handshake (ACCESS).
  task automatic issue(input int g, input logic wr, input logic [1:0] len, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output bit got);
    got = 1'b0;
    @(negedge SYS_clk);
    REQ_write[g] = wr;
    REQ_length[2*g +: 2] = len;
    REQ_signed[g] = sg;
    REQ_addr[32*g +: 32] = a;
    REQ_wdata[32*g +: 32] = wd;
    REQ_valid[g] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (REQ_ready[g]) begin
        got = 1'b1;
        break;
      end
      @(negedge SYS_clk);
    end
    if (got) begin
      @(posedge SYS_clk);
      @(negedge SYS_clk);
    end
    REQ_valid[g] = 1'b0;
  endtask

  task automatic wait_rsp(input int g, output logic [31:0] rd, output logic e, output bit got);
    got = 1'b0;
    rd  = 'x;
    e   = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (RSP_valid[g]) begin
        rd  = RSP_rdata;
        e   = RSP_err;
        got = 1'b1;
        break;
      end
      @(negedge SYS_clk);
    end
    if (got) @(negedge SYS_clk);
  endtask

  task automatic transact(input int g, input logic wr, input logic [1:0] len, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic e);
    bit got;
    rd = 'x;
    e  = 1'bx;
    issue(g, wr, len, sg, a, wd, got);
    if (got) wait_rsp(g, rd, e, got);
  endtask

  task automatic test_reset();
    SYS_reset = 1'b1;
    #2 SYS_reset = 1'b0;
    REQ_valid = 2'b11;
    repeat (2) @(negedge SYS_clk);
    n_cmp++; if (REQ_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", REQ_ready); end
    n_cmp++; if ({RSP_valid, RSP_err, RSP_rdata} !== 35'h0) begin
      n_bad++; $display("FAIL reset_rsp: got %b %b %h want 00 0 0", RSP_valid, RSP_err, RSP_rdata); end
    n_cmp++; if ({MEM_write_length, MEM_read_length, MEM_read_signed} !== 5'b00110) begin
      n_bad++; $display("FAIL reset_mem_ctl: got %b %b %b want 00 11 0",
                        MEM_write_length, MEM_read_length, MEM_read_signed); end
    n_cmp++; if ({MEM_read_address, MEM_write_address, MEM_write_data} !== 96'h0) begin
      n_bad++; $display("FAIL reset_mem_bus: got %h %h %h want 0", MEM_read_address,
                        MEM_write_address, MEM_write_data); end
    REQ_valid = 2'b00;
    @(negedge SYS_clk);
    SYS_reset = 1'b1;
  endtask

  task automatic test_store_word();
    logic [31:0] rd;
    logic e;
    bit got;
    transact(0, 1'b1, 2'b01, 1'b0, 32'd1, 32'h0000005A, rd, e);
    n_cmp++; if ({e, rd, mem[1]} !== {1'b0, 32'h0, 8'h5A}) begin
      n_bad++; $display("FAIL store_byte: got err %b rdata %h mem1 %h want 0 0 5a", e, rd, mem[1]); end
    issue(0, 1'b1, 2'b11, 1'b0, 32'd4, 32'h11223344, got);
    n_cmp++; if ({got, RSP_valid, MEM_write_length} !== 5'b10011) begin
      n_bad++; $display("FAIL store_access: got hs %b rsp_valid %b wlen %b want 1 00 11",
                        got, RSP_valid, MEM_write_length); end
    @(negedge SYS_clk);
    n_cmp++; if ({RSP_valid, RSP_err, RSP_rdata} !== {2'b01, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL store_rsp: got %b %b %h want 01 0 0", RSP_valid, RSP_err, RSP_rdata); end
    @(negedge SYS_clk);
    n_cmp++; if ({mem[4], mem[5], mem[6], mem[7], RSP_valid} !== {32'h11223344, 2'b00}) begin
      n_bad++; $display("FAIL store_mem: got %h%h%h%h rsp_valid %b want 11223344 00",
                        mem[4], mem[5], mem[6], mem[7], RSP_valid); end
  endtask

  task automatic test_load_sign();
    logic [31:0] rd;
    logic e;
    transact(1, 1'b1, 2'b01, 1'b0, 32'd4, 32'h00000080, rd, e);
    n_cmp++; if ({e, mem[4]} !== {1'b0, 8'h80}) begin
      n_bad++; $display("FAIL load_setup: got err %b mem4 %h want 0 80", e, mem[4]); end
    transact(1, 1'b0, 2'b01, 1'b1, 32'd4, 32'h0, rd, e);
    n_cmp++; if ({e, rd} !== {1'b0, 32'hFFFFFF80}) begin
      n_bad++; $display("FAIL load_sbyte: got %b %h want 0 ffffff80", e, rd); end
    transact(1, 1'b0, 2'b01, 1'b0, 32'd4, 32'h0, rd, e);
    n_cmp++; if ({e, rd} !== {1'b0, 32'h00000080}) begin
      n_bad++; $display("FAIL load_ubyte: got %b %h want 0 00000080", e, rd); end
    transact(1, 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, rd, e);
    n_cmp++; if ({e, rd} !== {1'b0, 32'h00008022}) begin
      n_bad++; $display("FAIL load_uhalf: got %b %h want 0 00008022", e, rd); end
    transact(1, 1'b0, 2'b10, 1'b1, 32'd4, 32'h0, rd, e);
    n_cmp++; if ({e, rd} !== {1'b0, 32'hFFFF8022}) begin
      n_bad++; $display("FAIL load_shalf: got %b %h want 0 ffff8022", e, rd); end
  endtask

  task automatic test_round_robin();
    int base;
    logic [3:0] order;
    base = grant_log.size();
    @(negedge SYS_clk);
    REQ_write = 2'b00;
    REQ_length = 4'b1111;
    REQ_signed = 2'b00;
    REQ_addr = 64'h0;
    REQ_valid = 2'b11;
    for (int i = 0; i < 60; i++) begin
      if (grant_log.size() >= base + 4) break;
      @(negedge SYS_clk);
    end
    REQ_valid = 2'b00;
    order = 4'hF;
    if (grant_log.size() >= base + 4)
      for (int k = 0; k < 4; k++) order[3-k] = grant_log[base+k][0];
    n_cmp++; if (order !== 4'b0101) begin
      n_bad++; $display("FAIL rr_order: got %b want 0101", order); end
    n_cmp++; if (both_ready_seen !== 1'b0) begin
      n_bad++; $display("FAIL rr_ready11: got %b want 0", both_ready_seen); end
    repeat (3) @(negedge SYS_clk);
  endtask

  task automatic test_bounds();
    logic [31:0] rd;
    logic e;
    int w0;
    w0 = n_writes;
    transact(0, 1'b1, 2'b11, 1'b0, 32'd97, 32'hDEADBEEF, rd, e);
    n_cmp++; if ({e, rd} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL bnd_word97: got %b %h want 1 0", e, rd); end
    n_cmp++; if (n_writes != w0 || {mem[97], mem[98], mem[99]} !== 24'h0) begin
      n_bad++; $display("FAIL bnd_nowrite: got writes %0d mem %h%h%h want %0d 000000",
                        n_writes, mem[97], mem[98], mem[99], w0); end
    transact(0, 1'b1, 2'b01, 1'b0, 32'd99, 32'h000000A5, rd, e);
    n_cmp++; if ({e, mem[99]} !== {1'b0, 8'hA5}) begin
      n_bad++; $display("FAIL bnd_byte99: got err %b mem99 %h want 0 a5", e, mem[99]); end
    transact(1, 1'b0, 2'b01, 1'b0, 32'd99, 32'h0, rd, e);
    n_cmp++; if ({e, rd} !== {1'b0, 32'h000000A5}) begin
      n_bad++; $display("FAIL bnd_load99: got %b %h want 0 000000a5", e, rd); end
    transact(1, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, rd, e);
    n_cmp++; if ({e, rd} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL bnd_wrap: got %b %h want 1 0", e, rd); end
    transact(0, 1'b0, 2'b00, 1'b0, 32'd4, 32'h0, rd, e);
    n_cmp++; if ({e, rd} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL bnd_len00: got %b %h want 1 0", e, rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic e;
    bit got;
    RSP_ready = 2'b00;
    issue(0, 1'b0, 2'b11, 1'b0, 32'd4, 32'h0, got);
    @(negedge SYS_clk);
    REQ_write[1] = 1'b0;
    REQ_length[3:2] = 2'b01;
    REQ_signed[1] = 1'b0;
    REQ_addr[63:32] = 32'd5;
    REQ_valid[1] = 1'b1;
    RSP_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if ({RSP_valid, RSP_err, REQ_ready, RSP_rdata} !== {2'b01, 1'b0, 2'b00, 32'h80223344})
        begin n_bad++; $display("FAIL bp_hold%0d: got %b %b %b %h want 01 0 00 80223344",
                                i, RSP_valid, RSP_err, REQ_ready, RSP_rdata); end
      @(negedge SYS_clk);
    end
    RSP_ready = 2'b11;
    @(negedge SYS_clk);
    #1;
    n_cmp++; if (REQ_ready !== 2'b10) begin
      n_bad++; $display("FAIL bp_release: got %b want 10", REQ_ready); end
    @(negedge SYS_clk);
    REQ_valid[1] = 1'b0;
    wait_rsp(1, rd, e, got);
    n_cmp++; if ({e, rd} !== {1'b0, 32'h00000022}) begin
      n_bad++; $display("FAIL bp_req1: got %b %h want 0 00000022", e, rd); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    logic e;
    bit got;
    int w0;
    w0 = n_writes;
    issue(0, 1'b1, 2'b01, 1'b0, 32'd10, 32'h000000AB, got);
    n_cmp++; if ({got, MEM_write_length} !== 3'b101) begin
      n_bad++; $display("FAIL rst_pre: got hs %b wlen %b want 1 01", got, MEM_write_length); end
    SYS_reset = 1'b0;
    #1;
    n_cmp++; if ({RSP_valid, MEM_write_length} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_outs: got %b %b want 00 00", RSP_valid, MEM_write_length); end
    @(negedge SYS_clk);
    n_cmp++; if (n_writes != w0 || mem[10] !== 8'h00 || RSP_valid !== 2'b00) begin
      n_bad++; $display("FAIL rst_nowrite: got writes %0d mem10 %h rsp_valid %b want %0d 00 00",
                        n_writes, mem[10], RSP_valid, w0); end
    SYS_reset = 1'b1;
    transact(0, 1'b1, 2'b01, 1'b0, 32'd10, 32'h0000003C, rd, e);
    transact(0, 1'b0, 2'b01, 1'b0, 32'd10, 32'h0, rd, e);
    n_cmp++; if ({e, rd} !== {1'b0, 32'h0000003C}) begin
      n_bad++; $display("FAIL rst_after: got %b %h want 0 0000003c", e, rd); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    REQ_valid = 2'b00; REQ_write = 2'b00; REQ_length = 4'h0; REQ_signed = 2'b00;
    REQ_addr = 64'h0; REQ_wdata = 64'h0; RSP_ready = 2'b11;
    test_reset();
    test_store_word();
    test_load_sign();
    test_round_robin();
    test_bounds();
    test_backpressure();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
